// File: rtl/lcd_write_scheduler.sv
// Character-LCD bus owner: init pass-through, then each byte as two timed nibbles plus execution wait; outputs registered (1-cycle latency).
// REQ_READY only in IDLE, requester holds REQ_VALID; LCD_LINE_WRAP_EN adds cursor tracking with an inserted line-jump command.
module lcd_write_scheduler #(
    parameter int T_SETUP   = 2,
    parameter int T_EPULSE  = 12,
    parameter int T_NIB_GAP = 50,
    parameter int T_CMD     = 2000,
    parameter int T_CLEAR   = 82000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       INIT_DONE,
    input  logic [3:0] INIT_SF_D,
    input  logic       INIT_E,
    input  logic       REQ_VALID,
    input  logic       REQ_RS,
    input  logic [7:0] REQ_DATA,
    output logic       REQ_READY,
    output logic [3:0] SF_D,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       BUSY
);
    localparam int M1    = (T_SETUP > T_EPULSE) ? T_SETUP : T_EPULSE;
    localparam int M2    = (M1 > T_NIB_GAP) ? M1 : T_NIB_GAP;
    localparam int M3    = (M2 > T_CMD) ? M2 : T_CMD;
    localparam int T_MAX = (M3 > T_CLEAR) ? M3 : T_CLEAR;
    localparam int CW    = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        S_PASS, S_IDLE, S_HI_SETUP, S_HI_PULSE, S_GAP, S_LO_SETUP, S_LO_PULSE, S_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, dur;
    logic [7:0]    byte_q, byte_d;
    logic          rs_q, rs_d;
    logic [3:0]    dat_q, dat_d;
    logic          e_q, e_d, lrs_q, lrs_d, rdy_q, rdy_d, busy_q, busy_d;
    logic          is_clear, last;
`ifdef LCD_LINE_WRAP_EN
    logic [3:0]    col_q, col_d;
    logic          line_q, line_d, wrap_q, wrap_d;
`endif

    // Clear display / return home need the long execution wait
    assign is_clear = !rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03);

    always_comb begin
        dur = '0;
        case (state_q)
            S_HI_SETUP, S_LO_SETUP: dur = CW'(T_SETUP);
            S_HI_PULSE, S_LO_PULSE: dur = CW'(T_EPULSE);
            S_GAP:                  dur = CW'(T_NIB_GAP);
            S_WAIT:                 dur = is_clear ? CW'(T_CLEAR) : CW'(T_CMD);
            default:                dur = '0;
        endcase
    end

    assign last = (cnt_q == dur - 1'b1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        byte_d  = byte_q;
        rs_d    = rs_q;
`ifdef LCD_LINE_WRAP_EN
        col_d   = col_q;
        line_d  = line_q;
        wrap_d  = wrap_q;
`endif
        case (state_q)
            S_PASS: begin
                cnt_d = '0;
                if (INIT_DONE) state_d = S_IDLE;
            end
            S_IDLE: begin
                cnt_d = '0;
                if (REQ_VALID && rdy_q) begin
                    state_d = S_HI_SETUP;
                    byte_d  = REQ_DATA;
                    rs_d    = REQ_RS;
`ifdef LCD_LINE_WRAP_EN
                    if (REQ_RS) begin
                        col_d = col_q + 4'd1;
                        if (col_q == 4'hF) wrap_d = 1'b1;
                    end else if (REQ_DATA == 8'h01 || REQ_DATA == 8'h02 || REQ_DATA == 8'h03) begin
                        col_d  = '0;
                        line_d = 1'b0;
                    end else if (REQ_DATA[7]) begin
                        line_d = REQ_DATA[6];
                        col_d  = REQ_DATA[3:0];
                    end
`endif
                end
            end
            S_HI_SETUP: if (last) state_d = S_HI_PULSE;
            S_HI_PULSE: if (last) state_d = S_GAP;
            S_GAP:      if (last) state_d = S_LO_SETUP;
            S_LO_SETUP: if (last) state_d = S_LO_PULSE;
            S_LO_PULSE: if (last) state_d = S_WAIT;
            S_WAIT: begin
                if (last) begin
                    state_d = S_IDLE;
`ifdef LCD_LINE_WRAP_EN
                    // Column 15 was just written: jump to the start of the other line
                    if (wrap_q) begin
                        state_d = S_HI_SETUP;
                        rs_d    = 1'b0;
                        byte_d  = line_q ? 8'h80 : 8'hC0;
                        line_d  = !line_q;
                        col_d   = '0;
                        wrap_d  = 1'b0;
                    end
`endif
                end
            end
            default: state_d = S_PASS;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_comb begin
        dat_d  = dat_q;
        e_d    = 1'b0;
        lrs_d  = rs_d;
        rdy_d  = (state_d == S_IDLE);
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_PASS: begin
                dat_d = INIT_SF_D;
                e_d   = INIT_E;
                lrs_d = 1'b0;
            end
            S_IDLE: lrs_d = lrs_q;
            S_HI_SETUP, S_GAP: dat_d = byte_d[7:4];
            S_HI_PULSE: begin
                dat_d = byte_d[7:4];
                e_d   = 1'b1;
            end
            S_LO_SETUP, S_WAIT: dat_d = byte_d[3:0];
            S_LO_PULSE: begin
                dat_d = byte_d[3:0];
                e_d   = 1'b1;
            end
            default: dat_d = dat_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_PASS;
            cnt_q   <= '0;
            byte_q  <= '0;
            rs_q    <= 1'b0;
            dat_q   <= '0;
            e_q     <= 1'b0;
            lrs_q   <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            rs_q    <= rs_d;
            dat_q   <= dat_d;
            e_q     <= e_d;
            lrs_q   <= lrs_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
        end
    end

`ifdef LCD_LINE_WRAP_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            col_q  <= '0;
            line_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            col_q  <= col_d;
            line_q <= line_d;
            wrap_q <= wrap_d;
        end
    end
`endif

    assign SF_D      = dat_q;
    assign LCD_E     = e_q;
    assign LCD_RS    = lrs_q;
    assign LCD_RW    = 1'b0;
    assign REQ_READY = rdy_q;
    assign BUSY      = busy_q;
endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Bench for lcd_write_scheduler: random byte traffic against a queue-based model of bus bytes and busy spans.
module tb_lcd_write_scheduler;
    localparam int T_SETUP   = 2;
    localparam int T_EPULSE  = 4;
    localparam int T_NIB_GAP = 7;
    localparam int T_CMD     = 30;
    localparam int T_CLEAR   = 90;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       INIT_DONE = 1'b0;
    logic [3:0] INIT_SF_D = '0;
    logic       INIT_E = 1'b0;
    logic       REQ_VALID = 1'b0;
    logic       REQ_RS = 1'b0;
    logic [7:0] REQ_DATA = '0;
    logic       REQ_READY;
    logic [3:0] SF_D;
    logic       LCD_E, LCD_RS, LCD_RW, BUSY;

    lcd_write_scheduler #(
        .T_SETUP(T_SETUP), .T_EPULSE(T_EPULSE), .T_NIB_GAP(T_NIB_GAP),
        .T_CMD(T_CMD), .T_CLEAR(T_CLEAR)
    ) dut (
        .CLK(CLK), .RST(RST), .INIT_DONE(INIT_DONE), .INIT_SF_D(INIT_SF_D), .INIT_E(INIT_E),
        .REQ_VALID(REQ_VALID), .REQ_RS(REQ_RS), .REQ_DATA(REQ_DATA), .REQ_READY(REQ_READY),
        .SF_D(SF_D), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .BUSY(BUSY)
    );

    always #10 CLK = ~CLK;

    typedef struct packed {
        logic       rs;
        logic [7:0] dat;
    } bus_byte_t;

    bus_byte_t  exp_q[$];
    int         span_q[$];
    logic [8:0] stim_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    logic       mon_en = 1'b0;
    logic       b2b_mode = 1'b0;
    int         m_col = 0;
    int         m_line = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int byte_time(input logic rs, input logic [7:0] d);
        int w;
        w = (!rs && d >= 8'd1 && d <= 8'd3) ? T_CLEAR : T_CMD;
        return 2 * T_SETUP + 2 * T_EPULSE + T_NIB_GAP + w;
    endfunction

    // Reference model: what the bus must carry and how long READY stays low per accepted byte
    task automatic model_accept(input logic rs, input logic [7:0] d);
        bus_byte_t b;
        int        span;
        b.rs  = rs;
        b.dat = d;
        exp_q.push_back(b);
        span = byte_time(rs, d);
`ifdef LCD_LINE_WRAP_EN
        if (rs) begin
            if (m_col == 15) begin
                b.rs  = 1'b0;
                b.dat = (m_line != 0) ? 8'h80 : 8'hC0;
                exp_q.push_back(b);
                span  = span + byte_time(1'b0, b.dat);
                m_line = 1 - m_line;
                m_col  = 0;
            end else m_col++;
        end else if (d >= 8'd1 && d <= 8'd3) begin
            m_col  = 0;
            m_line = 0;
        end else if (d[7]) begin
            m_line = int'(d[6]);
            m_col  = int'(d[3:0]);
        end
`endif
        span_q.push_back(span);
    endtask

    function automatic logic [8:0] rand_item();
        logic       rs;
        logic [7:0] d;
        rs = 1'($urandom);
        d  = 8'($urandom);
        if (!rs && $urandom_range(0, 3) == 0) d = 8'($urandom_range(1, 3));
        return {rs, d};
    endfunction

    task automatic drive_list(input logic b2b);
        int         guard;
        int         budget;
        logic       pending;
        logic [8:0] it;
        guard   = 0;
        pending = 1'b0;
        budget  = stim_q.size() * 400 + 100;
        while ((stim_q.size() != 0 || pending) && guard < budget) begin
            @(negedge CLK);
            guard++;
            INIT_DONE = 1'($urandom);
            INIT_E    = 1'($urandom);
            INIT_SF_D = 4'($urandom);
            if (!pending) begin
                if (b2b || $urandom_range(0, 2) == 0) begin
                    it = stim_q.pop_front();
                    REQ_RS    = it[8];
                    REQ_DATA  = it[7:0];
                    REQ_VALID = 1'b1;
                    pending   = 1'b1;
                end else begin
                    REQ_VALID = 1'b0;
                    REQ_RS    = 1'($urandom);
                    REQ_DATA  = 8'($urandom);
                end
            end
            if (pending && REQ_READY) begin
                model_accept(REQ_RS, REQ_DATA);
                pending = 1'b0;
            end
        end
        check("stim_all_accepted", stim_q.size() + int'(pending), 0);
        stim_q.delete();
        @(negedge CLK);
        REQ_VALID = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || span_q.size() != 0) && t < 3000) begin
            @(negedge CLK);
            t++;
        end
        check("drained_in_time", exp_q.size() + span_q.size(), 0);
    endtask

    task automatic run_list(input logic b2b);
        b2b_mode = b2b;
        drive_list(b2b);
        drain();
        b2b_mode = 1'b0;
        @(negedge CLK);
    endtask

    // Bus monitor: rebuilds bytes from E pulses and checks timing
    int         hi_len, lo_len, gap_len, stab_len, nib_cnt;
    logic       e_prev, hi_rs, lo_rs;
    logic [4:0] last_bus;
    logic [3:0] hi_nib, lo_nib;
    bus_byte_t  exp_b;
    initial forever begin
        @(negedge CLK);
        if (RST || !mon_en) begin
            e_prev = 1'b0; hi_len = 0; lo_len = 0; gap_len = 0; stab_len = 0; nib_cnt = 0;
            last_bus = {LCD_RS, SF_D};
        end else begin
            if ({LCD_RS, SF_D} == last_bus) stab_len++;
            else stab_len = 1;
            if (LCD_E && !e_prev) begin
                check("setup_cycles_ok", int'(stab_len - 1 >= T_SETUP), 1);
                if (nib_cnt == 0) begin
                    hi_nib = SF_D; hi_rs = LCD_RS;
                end else begin
                    lo_nib = SF_D; lo_rs = LCD_RS; gap_len = lo_len;
                end
                hi_len = 0;
            end
            if (LCD_E) begin
                if (hi_len > 0) check("bus_stable_while_e", int'({LCD_RS, SF_D}), int'(last_bus));
                hi_len++;
            end else begin
                if (e_prev) begin
                    check("e_pulse_cycles", hi_len, T_EPULSE);
                    if (nib_cnt == 0) begin
                        nib_cnt = 1;
                        lo_len  = 0;
                    end else begin
                        nib_cnt = 0;
                        check("byte_expected", int'(exp_q.size() > 0), 1);
                        if (exp_q.size() > 0) begin
                            exp_b = exp_q.pop_front();
                            check("byte_data", int'({hi_nib, lo_nib}), int'(exp_b.dat));
                            check("rs_hi_nibble", int'(hi_rs), int'(exp_b.rs));
                            check("rs_lo_nibble", int'(lo_rs), int'(exp_b.rs));
                            check("nibble_gap_cycles", gap_len, T_NIB_GAP + T_SETUP);
                        end
                    end
                end
                lo_len++;
            end
            e_prev   = LCD_E;
            last_bus = {LCD_RS, SF_D};
        end
    end

    // Handshake monitor: READY-low span per byte, BUSY/READY relation, back-to-back spacing
    int   lo_run, hi_run;
    logic b2b_armed;
    initial forever begin
        @(negedge CLK);
        if (RST || !mon_en) begin
            lo_run = 0; hi_run = 0; b2b_armed = 1'b0;
        end else begin
            if (!b2b_mode) b2b_armed = 1'b0;
            check("busy_is_not_ready", int'(BUSY), int'(!REQ_READY));
            check("rw_low", int'(LCD_RW), 0);
            if (REQ_READY) begin
                check("e_low_in_idle", int'(LCD_E), 0);
                if (lo_run > 0) begin
                    check("span_expected", int'(span_q.size() > 0), 1);
                    if (span_q.size() > 0) check("ready_low_cycles", lo_run, span_q.pop_front());
                end
                lo_run = 0;
                hi_run++;
            end else begin
                if (hi_run > 0 && b2b_mode) begin
                    if (b2b_armed) check("b2b_idle_cycles", hi_run, 1);
                    b2b_armed = 1'b1;
                end
                hi_run = 0;
                lo_run++;
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        logic       e;
        logic [3:0] s;
        int         t;
        repeat (3) @(negedge CLK);
        check("rst_e", int'(LCD_E), 0);
        check("rst_sfd", int'(SF_D), 0);
        check("rst_rs", int'(LCD_RS), 0);
        check("rst_rw", int'(LCD_RW), 0);
        check("rst_ready", int'(REQ_READY), 0);
        check("rst_busy", int'(BUSY), 1);

        RST = 1'b0;
        for (int i = 0; i < 8; i++) begin
            e = 1'($urandom);
            s = 4'($urandom);
            INIT_E    = e;
            INIT_SF_D = s;
            @(negedge CLK);
            check("pass_e", int'(LCD_E), int'(e));
            check("pass_sfd", int'(SF_D), int'(s));
            check("pass_rs", int'(LCD_RS), 0);
            check("pass_ready", int'(REQ_READY), 0);
        end
        INIT_DONE = 1'b1;
        INIT_E    = 1'b1;
        @(negedge CLK);
        check("idle_e", int'(LCD_E), 0);
        check("idle_ready", int'(REQ_READY), 1);
        check("idle_busy", int'(BUSY), 0);
        mon_en = 1'b1;

        stim_q.push_back({1'b1, 8'h41});
        stim_q.push_back({1'b0, 8'h01});
        run_list(1'b0);

        for (int i = 0; i < 40; i++) stim_q.push_back(rand_item());
        run_list(1'b0);

        stim_q.push_back({1'b1, 8'h31});
        stim_q.push_back({1'b0, 8'h02});
        stim_q.push_back({1'b1, 8'h7E});
        for (int i = 0; i < 20; i++) stim_q.push_back(rand_item());
        run_list(1'b1);

        for (int i = 0; i < 32; i++) stim_q.push_back({1'b1, 8'($urandom_range(32, 126))});
        stim_q.push_back({1'b0, 8'h85});
        for (int i = 0; i < 11; i++) stim_q.push_back({1'b1, 8'($urandom_range(32, 126))});
        run_list(1'b1);

        stim_q.push_back({1'b1, 8'h5A});
        drive_list(1'b0);
        t = 0;
        while (!LCD_E && t < 100) begin
            @(negedge CLK);
            t++;
        end
        check("reached_hi_pulse", int'(LCD_E), 1);
        RST = 1'b1; INIT_DONE = 1'b0; INIT_E = 1'b0; mon_en = 1'b0;
        @(negedge CLK);
        check("abort_e", int'(LCD_E), 0);
        check("abort_sfd", int'(SF_D), 0);
        check("abort_rs", int'(LCD_RS), 0);
        check("abort_ready", int'(REQ_READY), 0);
        check("abort_busy", int'(BUSY), 1);
        exp_q.delete();
        span_q.delete();
        m_col = 0;
        m_line = 0;

        RST = 1'b0; INIT_E = 1'b1; INIT_SF_D = 4'hA;
        @(negedge CLK);
        check("repass_e", int'(LCD_E), 1);
        check("repass_sfd", int'(SF_D), 10);
        check("repass_ready", int'(REQ_READY), 0);
        INIT_DONE = 1'b1; INIT_E = 1'b0;
        @(negedge CLK);
        check("reidle_ready", int'(REQ_READY), 1);
        mon_en = 1'b1;
        for (int i = 0; i < 6; i++) stim_q.push_back(rand_item());
        run_list(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
